// File: rtl/progmem_pkg.sv
// Shared types and constants for the program memory responder and its loader.
// PROGMEM_CHECKSUM_EN adds the CSUM state for the optional image trailer byte.
package progmem_pkg;

`ifdef PROGMEM_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, HDR, BODY, CSUM, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, HDR, BODY, DONE} state_t;
`endif

  localparam logic [7:0]  OP_END            = 8'hF0;
  localparam logic [31:0] DEFAULT_FILL_WORD = {OP_END, 24'h00_0000};
  localparam int          HDR_LEN           = 2;

endpackage

// File: rtl/progmem_loader.sv
// Byte-serial image loader: header/body/trailer FSM, word assembly and flags.
// PROGMEM_CHECKSUM_EN enables the trailer byte and the 8-bit zero-sum check.
module progmem_loader
  import progmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_start,
  input  logic [7:0]    load_data,
  input  logic          load_valid,
  output logic          load_ready,
  output logic          cpu_hold,
  output logic          load_done,
  output logic          load_ovf,
  output logic          checksum_err,
  output logic [15:0]   words_loaded,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [31:0]   wr_data
);

`ifdef PROGMEM_CHECKSUM_EN
  localparam state_t TAIL = CSUM;
  logic [7:0] sum;
  logic       cerr;
`else
  localparam state_t TAIL = DONE;
`endif

  state_t      state, state_d;
  logic [1:0]  hdr_cnt;
  logic [7:0]  n_hi;
  logic [15:0] n_words;
  logic [15:0] n_hdr;
  logic [1:0]  byte_cnt;
  logic [23:0] shreg;
  logic [15:0] wr_ptr;
  logic        accept;
  logic        last_body;
  logic        in_range;

  // A byte coinciding with load_start is dropped, never accepted.
  assign accept    = load_valid && load_ready && !load_start;
  assign n_hdr     = {n_hi, load_data};
  assign last_body = (byte_cnt == 2'd3) && (wr_ptr == n_words - 16'd1);
  assign in_range  = 32'(wr_ptr) < DEPTH;

  assign wr_en   = accept && (state == BODY) && (byte_cnt == 2'd3) && in_range;
  assign wr_addr = wr_ptr[AW-1:0];
  assign wr_data = {shreg, load_data};

  always_comb begin
    state_d = state;
    if (load_start) begin
      state_d = HDR;
    end else if (accept) begin
      case (state)
        HDR:  if (hdr_cnt == 2'(HDR_LEN - 1)) state_d = (n_hdr == '0) ? TAIL : BODY;
        BODY: if (last_body) state_d = TAIL;
`ifdef PROGMEM_CHECKSUM_EN
        CSUM: state_d = (sum + load_data == 8'h00) ? DONE : IDLE;
`endif
        default: ;
      endcase
    end
  end

  // Status outputs are registered decodes of the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      load_ready <= 1'b0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
    end else begin
      state      <= state_d;
      load_ready <= (state_d != IDLE) && (state_d != DONE);
      cpu_hold   <= (state_d != DONE);
      load_done  <= (state_d == DONE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hdr_cnt      <= '0;
      n_hi         <= '0;
      n_words      <= '0;
      byte_cnt     <= '0;
      shreg        <= '0;
      wr_ptr       <= '0;
      words_loaded <= '0;
      load_ovf     <= 1'b0;
    end else if (load_start) begin
      hdr_cnt      <= '0;
      n_words      <= '0;
      byte_cnt     <= '0;
      wr_ptr       <= '0;
      words_loaded <= '0;
      load_ovf     <= 1'b0;
    end else if (accept) begin
      case (state)
        HDR: begin
          hdr_cnt <= hdr_cnt + 2'd1;
          if (hdr_cnt == 2'd0) n_hi <= load_data;
          else                 n_words <= n_hdr;
        end
        BODY: begin
          shreg    <= {shreg[15:0], load_data};
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            wr_ptr <= wr_ptr + 16'd1;
            if (words_loaded != '1) words_loaded <= words_loaded + 16'd1;
            if (!in_range) load_ovf <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PROGMEM_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum  <= '0;
      cerr <= 1'b0;
    end else if (load_start) begin
      sum  <= '0;
      cerr <= 1'b0;
    end else if (accept) begin
      sum <= sum + load_data;
      if ((state == CSUM) && (sum + load_data != 8'h00)) cerr <= 1'b1;
    end
  end
  assign checksum_err = cerr;
`else
  assign checksum_err = 1'b0;
`endif

endmodule

// File: rtl/progmem_responder.sv
// Program memory on the responder side of the instruction-fetch port, filled
// by progmem_loader. Optional trailer checksum via PROGMEM_CHECKSUM_EN.
module progmem_responder
  import progmem_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] FILL_WORD = DEFAULT_FILL_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] memaddr,
  output logic [31:0] memdata,
  input  logic        load_start,
  input  logic [7:0]  load_data,
  input  logic        load_valid,
  output logic        load_ready,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_ovf,
  output logic        checksum_err,
  output logic [15:0] words_loaded
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   mem [DEPTH];
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;

  progmem_loader #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_loader (
    .clk          (clk),
    .reset        (reset),
    .load_start   (load_start),
    .load_data    (load_data),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_ovf     (load_ovf),
    .checksum_err (checksum_err),
    .words_loaded (words_loaded),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data)
  );

  // Storage is deliberately not reset so contents survive a controller reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign memdata = (32'(memaddr) < DEPTH) ? mem[memaddr[AW-1:0]] : FILL_WORD;

endmodule

// File: tb/tb_progmem_responder.sv
// Self-checking bench: random and directed images against a queue-based model,
// with a DEPTH=4 instance sharing the load bus for overflow behaviour.
module tb_progmem_responder;

  localparam logic [31:0] FILL = 32'hF000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] memaddr;
  logic        load_start;
  logic [7:0]  load_data;
  logic        load_valid;

  logic [31:0] memdata,    memdata_s;
  logic        load_ready, load_ready_s;
  logic        cpu_hold,   cpu_hold_s;
  logic        load_done,  load_done_s;
  logic        load_ovf,   load_ovf_s;
  logic        cerr,       cerr_s;
  logic [15:0] words,      words_s;

  int checks   = 0;
  int failures = 0;

  logic [31:0] body_q[$];
  logic [7:0]  img_q[$];
  logic [31:0] ref_mem [8];
  bit          ref_vld [8];

  always #5 clk = ~clk;

  progmem_responder dut (
    .clk(clk), .reset(reset), .memaddr(memaddr), .memdata(memdata),
    .load_start(load_start), .load_data(load_data), .load_valid(load_valid),
    .load_ready(load_ready), .cpu_hold(cpu_hold), .load_done(load_done),
    .load_ovf(load_ovf), .checksum_err(cerr), .words_loaded(words)
  );

  progmem_responder #(.DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .memaddr(memaddr), .memdata(memdata_s),
    .load_start(load_start), .load_data(load_data), .load_valid(load_valid),
    .load_ready(load_ready_s), .cpu_hold(cpu_hold_s), .load_done(load_done_s),
    .load_ovf(load_ovf_s), .checksum_err(cerr_s), .words_loaded(words_s)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
    $fatal(1);
  end

  function automatic void build_image(input int n);
    logic [7:0] s;
    img_q.delete();
    img_q.push_back(8'(n >> 8));
    img_q.push_back(8'(n));
    foreach (body_q[k])
      for (int b = 3; b >= 0; b--) img_q.push_back(body_q[k][8*b +: 8]);
`ifdef PROGMEM_CHECKSUM_EN
    s = 8'h00;
    foreach (img_q[j]) s = s + img_q[j];
    img_q.push_back(8'h00 - s);
`endif
  endfunction

  function automatic void commit_model();
    foreach (body_q[k]) if (k < 8) begin ref_mem[k] = body_q[k]; ref_vld[k] = 1'b1; end
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    load_data  = b;
    load_valid = 1'b1;
    while (!load_ready && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (load_ready !== 1'b1) begin
      failures++;
      $display("FAIL byte_accept: load_ready=%b after %0d cycles, required 1", load_ready, n);
    end else begin
      @(negedge clk);
    end
    load_valid = 1'b0;
  endtask

  // mode 0: back-to-back, 1: alternate cycles plus a 10-cycle stall mid-word, 2: random gaps
  task automatic send_image(input int mode);
    for (int i = 0; i < img_q.size(); i++) begin
      send_byte(img_q[i]);
      if (mode == 1) begin
        @(negedge clk);
        if (i == 3) repeat (10) @(negedge clk);
      end else if (mode == 2) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; memaddr = 16'hFFFF; load_start = 1'b0; load_data = 8'h00; load_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (cpu_hold !== 1'b1)   begin failures++; $display("FAIL rst_hold: got %b need 1", cpu_hold); end
    checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL rst_ready: got %b need 0", load_ready); end
    checks++; if (load_done !== 1'b0)  begin failures++; $display("FAIL rst_done: got %b need 0", load_done); end
    checks++; if (load_ovf !== 1'b0)   begin failures++; $display("FAIL rst_ovf: got %b need 0", load_ovf); end
    checks++; if (cerr !== 1'b0)       begin failures++; $display("FAIL rst_cerr: got %b need 0", cerr); end
    checks++; if (words !== 16'd0)     begin failures++; $display("FAIL rst_words: got %0d need 0", words); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (memdata !== FILL)    begin failures++; $display("FAIL rst_fill_ffff: got %h need %h", memdata, FILL); end
    memaddr = 16'd1024; #1;
    checks++; if (memdata !== FILL)    begin failures++; $display("FAIL rst_fill_1024: got %h need %h", memdata, FILL); end
    memaddr = 16'd4; #1;
    checks++; if (memdata_s !== FILL)  begin failures++; $display("FAIL rst_fill4_4: got %h need %h", memdata_s, FILL); end
    checks++; if (load_ready !== 1'b0 || cpu_hold !== 1'b1) begin
      failures++; $display("FAIL idle_hold: ready=%b hold=%b need 0/1", load_ready, cpu_hold);
    end
  endtask

  task automatic load_and_check(input string tag, input int mode);
    build_image(body_q.size());
    pulse_start();
    checks++; if (cpu_hold !== 1'b1 || load_ready !== 1'b1) begin
      failures++; $display("FAIL %s_hdr: hold=%b ready=%b need 1/1", tag, cpu_hold, load_ready);
    end
    send_image(mode);
    commit_model();
    checks++; if (load_done !== 1'b1 || cpu_hold !== 1'b0 || load_ready !== 1'b0) begin
      failures++; $display("FAIL %s_done: done=%b hold=%b ready=%b need 1/0/0", tag, load_done, cpu_hold, load_ready);
    end
    checks++; if (words !== 16'(body_q.size())) begin
      failures++; $display("FAIL %s_words: got %0d need %0d", tag, words, body_q.size());
    end
    checks++; if (words_s !== 16'(body_q.size()) || load_ovf_s !== (body_q.size() > 4)) begin
      failures++; $display("FAIL %s_d4: words=%0d ovf=%b need %0d/%b", tag, words_s, load_ovf_s, body_q.size(), body_q.size() > 4);
    end
    checks++; if (load_ovf !== 1'b0 || cerr !== 1'b0) begin
      failures++; $display("FAIL %s_flags: ovf=%b cerr=%b need 0/0", tag, load_ovf, cerr);
    end
    for (int i = 0; i < 8; i++) if (ref_vld[i]) begin
      memaddr = 16'(i); #1;
      checks++; if (memdata !== ref_mem[i]) begin
        failures++; $display("FAIL %s_mem[%0d]: got %h need %h", tag, i, memdata, ref_mem[i]);
      end
      checks++; if (memdata_s !== ((i < 4) ? ref_mem[i] : FILL)) begin
        failures++; $display("FAIL %s_mem4[%0d]: got %h need %h", tag, i, memdata_s, (i < 4) ? ref_mem[i] : FILL);
      end
    end
  endtask

  task automatic test_directed();
    body_q = '{32'h1122_3344, 32'hF000_0000};
    load_and_check("b2b", 0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      body_q.delete();
      repeat ($urandom_range(1, 8)) body_q.push_back($urandom);
      load_and_check("rand", int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_gapped();
    body_q = '{32'h1122_3344, 32'hF000_0000};
    load_and_check("gap", 1);
  endtask

  task automatic test_overflow();
    body_q.delete();
    repeat (5) body_q.push_back($urandom);
    load_and_check("ovf", 0);
    checks++; if (load_done_s !== 1'b1 || cpu_hold_s !== 1'b0) begin
      failures++; $display("FAIL ovf_d4_done: done=%b hold=%b need 1/0", load_done_s, cpu_hold_s);
    end
  endtask

  task automatic test_zero_len();
    body_q.delete();
    load_and_check("zero", 0);
  endtask

`ifdef PROGMEM_CHECKSUM_EN
  task automatic test_checksum_bad();
    body_q = '{32'h1122_3344, 32'hF000_0000};
    build_image(2);
    img_q[img_q.size() - 1] = 8'h00;
    pulse_start();
    send_image(0);
    commit_model();
    checks++; if (cerr !== 1'b1) begin failures++; $display("FAIL csum_err: got %b need 1", cerr); end
    checks++; if (cpu_hold !== 1'b1 || load_done !== 1'b0 || load_ready !== 1'b0) begin
      failures++; $display("FAIL csum_idle: hold=%b done=%b ready=%b need 1/0/0", cpu_hold, load_done, load_ready);
    end
  endtask
`endif

  task automatic test_restart();
    body_q.delete();
    repeat (6) body_q.push_back($urandom);
    build_image(6);
    pulse_start();
    for (int i = 0; i < 22; i++) send_byte(img_q[i]);
    body_q = body_q[0:4];
    commit_model();
    checks++; if (words !== 16'd5 || load_ovf_s !== 1'b1) begin
      failures++; $display("FAIL rs_pre: words=%0d ovf4=%b need 5/1", words, load_ovf_s);
    end
    load_start = 1'b1; load_valid = 1'b1; load_data = 8'hA5;
    @(negedge clk);
    load_start = 1'b0; load_valid = 1'b0;
    checks++; if (load_ready !== 1'b1 || cpu_hold !== 1'b1 || load_done !== 1'b0) begin
      failures++; $display("FAIL rs_hdr: ready=%b hold=%b done=%b need 1/1/0", load_ready, cpu_hold, load_done);
    end
    checks++; if (words !== 16'd0 || words_s !== 16'd0 || load_ovf_s !== 1'b0) begin
      failures++; $display("FAIL rs_clear: words=%0d words4=%0d ovf4=%b need 0/0/0", words, words_s, load_ovf_s);
    end
    body_q = '{$urandom};
    build_image(1);
    send_image(0);
    commit_model();
    checks++; if (load_done !== 1'b1 || words !== 16'd1) begin
      failures++; $display("FAIL rs_load: done=%b words=%0d need 1/1", load_done, words);
    end
    memaddr = 16'd0; #1;
    checks++; if (memdata !== ref_mem[0]) begin
      failures++; $display("FAIL rs_mem0: got %h need %h", memdata, ref_mem[0]);
    end
  endtask

  task automatic test_reset_midload();
    body_q = '{$urandom, $urandom};
    build_image(2);
    pulse_start();
    for (int i = 0; i < 7; i++) send_byte(img_q[i]);
    body_q = body_q[0:0];
    commit_model();
    reset = 1'b0; #2;
    checks++; if (load_ready !== 1'b0 || cpu_hold !== 1'b1 || words !== 16'd0 || load_done !== 1'b0) begin
      failures++; $display("FAIL arst: ready=%b hold=%b words=%0d done=%b need 0/1/0/0", load_ready, cpu_hold, words, load_done);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) if (ref_vld[i]) begin
      memaddr = 16'(i); #1;
      checks++; if (memdata !== ref_mem[i]) begin
        failures++; $display("FAIL arst_mem[%0d]: got %h need %h", i, memdata, ref_mem[i]);
      end
    end
  endtask

  initial begin
    foreach (ref_vld[i]) ref_vld[i] = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_gapped();
    test_overflow();
    test_zero_len();
`ifdef PROGMEM_CHECKSUM_EN
    test_checksum_bad();
`endif
    test_restart();
    test_reset_midload();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
